ahb_apb_bridge_mslv: RTL
========================

// Module: ahb_apb_bridge_mslv
// PURPOSE
//  Parametrised AHB-Lite to APB bridge, successor to the fixed 3-slave bridge.
//  Decodes a configurable window into NUM_SLAVES APB slaves and supports APB wait states (PREADY).
//  Maps PSLVERR, bad decodes and timeouts onto the two-cycle AHB ERROR response.
//  Sits between the AHB master and the APB slave interfaces in the bridge top level.
// PARAMETERS
//  ADDR_W      32            AHB/APB address width
//  DATA_W      32            AHB/APB data width
//  NUM_SLAVES  3             number of APB slaves (PSELx width), 1..16
//  SLV_AW      12            byte-address bits per slave region (4 KiB each)
//  BASE_ADDR   32'h8000_0000 window base; bits below SLV_AW+IDX_W are ignored
//  TIMEOUT     16            max ACCESS wait cycles before forced error; 0 = no timeout
// PORTS
//  HCLK       in   1                  clock, rising edge
//  HRESETn    in   1                  asynchronous active-low reset
//  HSEL       in   1                  bridge selected
//  HADDR      in   ADDR_W             AHB address
//  HTRANS     in   2                  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HWRITE     in   1                  1 = write
//  HWDATA     in   DATA_W             write data (data phase)
//  HREADYin   in   1                  bus-wide ready
//  HREADYout  out  1                  bridge ready (registered)
//  HRESP      out  2                  00 OKAY, 01 ERROR
//  HRDATA     out  DATA_W             read data (registered)
//  PADDR      out  ADDR_W             APB address
//  PWDATA     out  DATA_W             APB write data
//  PWRITE     out  1                  APB direction
//  PENABLE    out  1                  APB access phase
//  PSELx      out  NUM_SLAVES         one-hot slave select
//  PRDATA     in   NUM_SLAVES*DATA_W  slave k read data at [k*DATA_W +: DATA_W]
//  PREADY     in   NUM_SLAVES         per-slave ready
//  PSLVERR    in   NUM_SLAVES         per-slave error
//  err_cnt    out  8                  saturating count of ERROR responses
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, HREADYout=1, HRESP=00, HRDATA=0, PSELx=0, PENABLE=0,
//    PWRITE=0, PADDR=0, PWDATA=0, err_cnt=0. Reset mid-transfer drops PSELx/PENABLE at once.
//  - Valid transfer = HSEL & HREADYin & HTRANS[1], sampled on the rising edge while in IDLE or ERR2.
//    On that edge HADDR, HWRITE and the decoded index are captured.
//  - Decode: IDX_W = clog2(NUM_SLAVES) (min 1); idx = HADDR[SLV_AW +: IDX_W].
//    Hit only if HADDR[ADDR_W-1 : SLV_AW+IDX_W] matches BASE_ADDR and idx < NUM_SLAVES.
//  - HSEL with IDLE/BUSY: OKAY, zero wait, no APB activity.
//  - States:
//    IDLE:  HREADYout=1. Valid miss -> ERR1. Valid write -> WDATA. Valid read -> SETUP.
//    WDATA: HREADYout=0. Latches HWDATA into PWDATA -> SETUP.
//    SETUP: PSELx[idx]=1, PENABLE=0, PADDR/PWRITE held -> ACCESS.
//    ACCESS: PENABLE=1, PSELx held. Exits on the first of:
//      - PREADY[idx]=1 & !PSLVERR[idx]: read latches the PRDATA slice into HRDATA -> IDLE (OKAY).
//      - PREADY[idx]=1 & PSLVERR[idx] -> ERR1.
//      - TIMEOUT!=0 and wait count == TIMEOUT -> ERR1.
//      Otherwise stays (wait count++).
//    ERR1:  HREADYout=0, HRESP=01, PSELx=0, PENABLE=0 -> ERR2.
//    ERR2:  HREADYout=1, HRESP=01; err_cnt++ (saturates at 255); samples like IDLE.
//  - Latency, address edge to HREADYout=1 with 0 APB waits: read 3 cycles, write 4; +1 per PREADY=0 cycle.
//  - HRDATA holds its last value; it is not cleared on writes or errors.
//  - PSELx is all-zero outside SETUP and ACCESS. The wait counter clears on leaving ACCESS.
// STRUCTURE
//  - Package ahb_apb_pkg: HTRANS encodings, HRESP encodings, state enum
//    (IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2).
//  - Sub-module apb_addr_decode (combinational): HADDR -> {hit, idx}.
//  - FSM, capture registers, wait counter and err_cnt live in the top.
// TESTING
//  1. Read 0x8000_1004, PRDATA1=0xDEAD_BEEF, PREADY=1 -> PSELx=010 in SETUP+ACCESS; HRDATA=0xDEAD_BEEF; 2 wait states; OKAY.
//  2. Write 0x8000_0010 with HWDATA=0x1234_5678 -> PWDATA=0x1234_5678, PWRITE=1 in SETUP/ACCESS; PSELx=001.
//  3. Read slave 2 with PREADY2 low for 3 ACCESS cycles -> HREADYout low 5 cycles; PENABLE high 4 cycles.
//  4. Access 0x8000_3000 (idx 3) or 0x9000_0000 -> no PSEL; HRESP=01 for 2 cycles, HREADYout 0 then 1; err_cnt=1.
//  5. PSLVERR0=1 with PREADY0=1 -> ERROR response; TIMEOUT=16 with PREADY stuck low -> ERROR after 16 waits.
//  6. Assert HRESETn=0 during ACCESS -> PSELx=0, PENABLE=0, HREADYout=1 immediately; next read completes normally.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared encodings and FSM state type for the AHB-Lite to APB bridge.
// Also provides the slave-index width helper used by decoder and top.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational window decoder: addr -> {hit, idx}.
// Ports: addr in; hit (inside window and idx valid), idx (slave index) out.
module apb_addr_decode #(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SLV_AW     = 12,
  parameter int IDX_W      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  localparam int TAG_LSB = SLV_AW + IDX_W;

  logic tag_ok;
  logic idx_ok;
  logic unused_low;

  assign idx    = addr[SLV_AW +: IDX_W];
  assign tag_ok = addr[ADDR_W-1:TAG_LSB]
               == BASE_ADDR[ADDR_W-1:TAG_LSB];
  // idx can exceed NUM_SLAVES-1 when the count is not a power of two
  assign idx_ok = 32'(idx) < 32'(NUM_SLAVES);
  assign hit    = tag_ok & idx_ok;

  assign unused_low = ^addr[SLV_AW-1:0];

endmodule

// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite to APB bridge for NUM_SLAVES slaves with PREADY waits,
// PSLVERR/decode-miss/timeout mapped to the two-cycle AHB ERROR.
// Ports: AHB slave side (HSEL..HRDATA), APB master side
// (PADDR..PSLVERR, one PSELx bit per slave), err_cnt error counter.
module ahb_apb_bridge_mslv #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SLV_AW     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int TIMEOUT    = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [DATA_W-1:0]            HWDATA,
  input  logic                         HREADYin,
  output logic                         HREADYout,
  output logic [1:0]                   HRESP,
  output logic [DATA_W-1:0]            HRDATA,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic                         PWRITE,
  output logic                         PENABLE,
  output logic [NUM_SLAVES-1:0]        PSELx,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR,
  output logic [7:0]                   err_cnt
);

  import ahb_apb_pkg::*;

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  wcnt;

  logic              hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              valid;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              timed_out;
  logic              unused_trans;

  apb_addr_decode #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_AW     (SLV_AW),
    .IDX_W      (IDX_W),
    .BASE_ADDR  (BASE_ADDR)
  ) u_dec (
    .addr (HADDR),
    .hit  (hit),
    .idx  (dec_idx)
  );

  assign valid        = HSEL & HREADYin & HTRANS[1];
  assign unused_trans = HTRANS[0];
  assign timed_out    = (TIMEOUT != 0)
                     && (wcnt == CNT_W'(TIMEOUT));

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready = PREADY[k];
        sel_err   = PSLVERR[k];
        sel_rdata = PRDATA[k*DATA_W +: DATA_W];
      end
    end
  end

  function automatic logic [NUM_SLAVES-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    return NUM_SLAVES'(1) << i;
  endfunction

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      wcnt      <= '0;
      HREADYout <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PENABLE   <= 1'b0;
      PSELx     <= '0;
      err_cnt   <= '0;
    end else begin
      unique case (state)
        // ERR2 is the last error cycle and samples like IDLE
        ST_IDLE, ST_ERR2: begin
          HREADYout <= 1'b1;
          HRESP     <= HRESP_OKAY;
          state     <= ST_IDLE;
          if (valid) begin
            PADDR     <= HADDR;
            PWRITE    <= HWRITE;
            idx_q     <= dec_idx;
            HREADYout <= 1'b0;
            if (!hit) begin
              state <= ST_ERR1;
              HRESP <= HRESP_ERROR;
            end else if (HWRITE) begin
              state <= ST_WDATA;
            end else begin
              state <= ST_SETUP;
              PSELx <= onehot(dec_idx);
            end
          end
        end
        ST_WDATA: begin
          PWDATA <= HWDATA;
          PSELx  <= onehot(idx_q);
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready || timed_out) begin
            PSELx   <= '0;
            PENABLE <= 1'b0;
            wcnt    <= '0;
            if (sel_ready && !sel_err) begin
              state     <= ST_IDLE;
              HREADYout <= 1'b1;
              if (!PWRITE) HRDATA <= sel_rdata;
            end else begin
              state <= ST_ERR1;
              HRESP <= HRESP_ERROR;
            end
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        ST_ERR1: begin
          HREADYout <= 1'b1;
          state     <= ST_ERR2;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        default: begin
          state     <= ST_IDLE;
          HREADYout <= 1'b1;
          HRESP     <= HRESP_OKAY;
          PSELx     <= '0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule
